// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory address from fetch_pc and
// buffers returned words with their PC in a small circular queue for decode.
module fetch_unit #(
    parameter int AW = 8,
    parameter int DW = 16,
    parameter int DEPTH = 2,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    output logic [AW-1:0]              imem_addr,
    input  logic [DW-1:0]              imem_data,
    output logic                       inst_valid,
    output logic [DW-1:0]              inst,
    output logic [AW-1:0]              inst_pc,
    input  logic                       inst_ready,
    input  logic                       redirect,
    input  logic [AW-1:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]     fill
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] fetch_pc;
    logic [DW-1:0] q_inst [DEPTH];
    logic [AW-1:0] q_pc   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          pop;
    logic          push;

    assign pop  = inst_valid & inst_ready;
    // A pop frees the slot the same cycle, so a full queue can still accept a word.
    assign push = en & ~redirect & ((count < FULL) | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                q_inst[wr_ptr] <= imem_data;
                q_pc[wr_ptr]   <= fetch_pc;
                wr_ptr         <= wr_ptr + PW'(1);
                fetch_pc       <= fetch_pc + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head outputs are forced to zero when empty so stale entries never leak out.
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? q_inst[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? q_pc[rd_ptr] : '0;
    assign imem_addr  = fetch_pc;
    assign fill       = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic compared against
// a queue-based reference model of the fetch stage.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        inst_valid;
    logic [15:0] inst;
    logic [7:0]  inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [1:0]  fill;

    logic [15:0] mem [256];

    typedef struct {
        logic [15:0] i;
        logic [7:0]  p;
    } entry_t;

    entry_t      q[$];
    logic [7:0]  mpc;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_unit #(.AW(8), .DW(16), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .fill(fill)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("valid", {31'b0, inst_valid}, {31'b0, q.size() != 0});
        chk("inst", {16'b0, inst}, (q.size() != 0) ? {16'b0, q[0].i} : 32'h0);
        chk("inst_pc", {24'b0, inst_pc}, (q.size() != 0) ? {24'b0, q[0].p} : 32'h0);
        chk("fill", {30'b0, fill}, q.size());
        chk("imem_addr", {24'b0, imem_addr}, {24'b0, mpc});
    endtask

    task automatic model_reset();
        q.delete();
        mpc = 8'h00;
    endtask

    // Apply the fetch rules to the model using the inputs presented this cycle,
    // then clock the DUT and compare.
    task automatic cycle();
        int sz;
        bit pop_m;
        sz = q.size();
        pop_m = (sz != 0) && inst_ready;
        if (redirect) begin
            q.delete();
            mpc = redirect_pc;
        end else begin
            if (pop_m) q.delete(0);
            if (en && (sz < DEPTH || pop_m)) begin
                q.push_back('{mem[mpc], mpc});
                mpc = mpc + 8'd1;
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_valid"}, {31'b0, inst_valid}, 32'h0);
        chk({tag, "_fill"}, {30'b0, fill}, 32'h0);
        chk({tag, "_inst"}, {16'b0, inst}, 32'h0);
        chk({tag, "_pc"}, {24'b0, inst_pc}, 32'h0);
        chk({tag, "_addr"}, {24'b0, imem_addr}, 32'h0);
    endtask

    initial begin
        logic [7:0] held;
        logic [7:0] wrap_pc [4];

        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        mem[0]     = 16'hC005;
        mem[1]     = 16'hC103;
        mem[2]     = 16'h0201;
        mem[3]     = 16'h0000;
        mem[13]    = 16'hB020;
        mem[8'h20] = 16'h1D24;

        rst_n = 1'b0; en = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        model_reset();
        #2;
        check_reset_zero("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1; en = 1'b1; inst_ready = 1'b1;

        // streaming from reset
        cycle();
        chk("s1_inst0", {16'b0, inst}, 32'hC005);
        chk("s1_pc0", {24'b0, inst_pc}, 32'h00);
        chk("s1_addr0", {24'b0, imem_addr}, 32'h01);
        cycle();
        chk("s1_inst1", {16'b0, inst}, 32'hC103);
        chk("s1_addr1", {24'b0, imem_addr}, 32'h02);
        cycle();
        chk("s1_inst2", {16'b0, inst}, 32'h0201);
        chk("s1_pc2", {24'b0, inst_pc}, 32'h02);
        cycle();
        cycle();

        // async reset mid-stream, then backpressure from reset
        rst_n = 1'b0;
        #2;
        check_reset_zero("async");
        model_reset();
        inst_ready = 1'b0;
        #1;
        rst_n = 1'b1;
        cycle();
        chk("bp_first", {16'b0, inst}, 32'hC005);
        chk("bp_fill1", {30'b0, fill}, 32'h1);
        cycle();
        chk("bp_fill2", {30'b0, fill}, 32'h2);
        chk("bp_addr2", {24'b0, imem_addr}, 32'h02);
        cycle();
        chk("bp_hold_inst", {16'b0, inst}, 32'hC005);
        chk("bp_hold_addr", {24'b0, imem_addr}, 32'h02);
        inst_ready = 1'b1;
        cycle();
        chk("bp_rel1", {16'b0, inst}, 32'hC103);
        chk("bp_rel1_fill", {30'b0, fill}, 32'h2);
        cycle();
        chk("bp_rel2", {16'b0, inst}, 32'h0201);
        chk("bp_rel2_pc", {24'b0, inst_pc}, 32'h02);

        // run to B020 at head with a full queue, then redirect to 0x20
        for (int i = 0; i < 40; i++) begin
            if (q.size() != 0 && q[0].p == 8'd13) break;
            cycle();
        end
        chk("rd_head", {16'b0, inst}, 32'hB020);
        chk("rd_full", {30'b0, fill}, 32'h2);
        redirect = 1'b1; redirect_pc = 8'h20;
        cycle();
        redirect = 1'b0;
        chk("rd_n1_valid", {31'b0, inst_valid}, 32'h0);
        chk("rd_n1_fill", {30'b0, fill}, 32'h0);
        chk("rd_n1_addr", {24'b0, imem_addr}, 32'h20);
        cycle();
        chk("rd_n2_inst", {16'b0, inst}, 32'h1D24);
        chk("rd_n2_pc", {24'b0, inst_pc}, 32'h20);

        // PC wrap
        redirect = 1'b1; redirect_pc = 8'hFE;
        cycle();
        redirect = 1'b0;
        wrap_pc[0] = 8'hFE; wrap_pc[1] = 8'hFF; wrap_pc[2] = 8'h00; wrap_pc[3] = 8'h01;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("wrap_pc", {24'b0, inst_pc}, {24'b0, wrap_pc[k]});
            chk("wrap_addr", {24'b0, imem_addr}, {24'b0, wrap_pc[k] + 8'd1});
        end

        // en=0 drain
        inst_ready = 1'b0;
        cycle();
        chk("dr_fill2", {30'b0, fill}, 32'h2);
        en = 1'b0; inst_ready = 1'b1;
        held = mpc;
        cycle();
        chk("dr_fill1", {30'b0, fill}, 32'h1);
        chk("dr_addr1", {24'b0, imem_addr}, {24'b0, held});
        cycle();
        chk("dr_empty_valid", {31'b0, inst_valid}, 32'h0);
        chk("dr_empty_inst", {16'b0, inst}, 32'h0);
        chk("dr_addr2", {24'b0, imem_addr}, {24'b0, held});
        cycle();
        chk("dr_addr3", {24'b0, imem_addr}, {24'b0, held});
        en = 1'b1;
        cycle();
        chk("dr_resume_pc", {24'b0, inst_pc}, {24'b0, held});
        chk("dr_resume_inst", {16'b0, inst}, {16'b0, mem[held]});

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            en          = ($urandom_range(0, 9) != 0);
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 8'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                #2;
                check_reset_zero("rnd_rst");
                model_reset();
                #1;
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multicycle CPU. It sits directly upstream of the instruction memory and drives the memory's 8-bit address with the program counter. It captures the 16-bit word the memory returns combinationally. Fetched words are buffered, each with its PC, in a small FIFO and handed to the decode/control stage over a valid/ready handshake. Decode can redirect fetch on jumps and flushes.

## Interface
- AW, 8, address/PC width; matches the instruction memory address.
- DW, 16, instruction width.
- DEPTH, 2, queue entries; a power of two, ≥2.
- RESET_PC, 0, fetch PC after reset.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset. This is the only clock and reset: one clock, reset asynchronous and active-low.
- en  input  1  fetch enable; 0 suspends new fetches, while the queue may still drain.
- imem_addr  output  AW  address to instruction memory; always equals fetch_pc (combinational from register).
- imem_data  input  DW  instruction word read at imem_addr, valid in the same cycle.
- inst_valid  output  1  queue head holds a valid instruction.
- inst  output  DW  queue head instruction.
- inst_pc  output  AW  PC of the queue head instruction.
- inst_ready  input  1  downstream accepts the head this cycle.
- redirect  input  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  input  AW  new fetch address.
- fill  output  $clog2(DEPTH)+1  current queue occupancy.

## Operation
- State: fetch_pc register, DEPTH-entry circular queue of {DW instruction, AW pc}, read/write pointers and a count.
- pop = inst_valid & inst_ready.
- push = en & ~redirect & (count < DEPTH | pop). Push writes {imem_data, fetch_pc} at the tail and increments fetch_pc modulo 2^AW, so 0xFF wraps to 0x00.
- Push and pop in the same cycle: both happen, count unchanged. This is legal when the queue is full.
- Redirect (highest priority): count←0, pointers←0, fetch_pc←redirect_pc. Any same-cycle push is suppressed and any same-cycle pop is discarded. The downstream must not treat an instruction popped in a redirect cycle as executed twice; decode owns that.
- Redirect while the queue is empty or en=0 has the same effect.
- en=0: no push; fetch_pc and imem_addr hold; pops continue until the queue is empty.
- inst_valid = (count != 0). inst and inst_pc come from the head entry. When empty they read 0; no X is allowed to propagate.
- No instruction decoding inside this block; every word, including 0x0000, is treated as an instruction.

## Timing
- Reset (asynchronous, immediate on rst_n low): fetch_pc=RESET_PC, imem_addr=RESET_PC, count=0, inst_valid=0, inst=0, inst_pc=0, fill=0.
- First instruction: with en=1 at the first clock edge after reset release, inst_valid=1 after that edge. Fetch latency is 1 cycle from address to queue head.
- Sustained throughput: 1 instruction per cycle when inst_ready stays 1.
- Redirect asserted in cycle N:
  - cycle N+1: inst_valid=0, imem_addr=redirect_pc.
  - cycle N+2 (en=1): inst_valid=1, inst_pc=redirect_pc.
- Backpressure: with inst_ready=0 the queue fills to DEPTH. fetch_pc then stalls at (head pc + DEPTH). No word is dropped or duplicated when inst_ready returns.
- Reset asserted mid-stream discards all queued entries. Fetching restarts at RESET_PC on the first edge after release.

## Test plan
- Memory preloaded with C005, C103, 0201, … (addresses 0..13), B020 at 13, 1D24 at 0x20; reset, en=1, inst_ready=1 → from cycle 1 inst/inst_pc = C005/00, C103/01, 0201/02, … one per cycle; imem_addr increments each cycle.
- Same program, inst_ready=0 from reset → fill=2, inst=C005, imem_addr stalls at 02. Then inst_ready=1 → 0201 follows C103 with no gap or repeat.
- When inst=B020 is at the head, assert redirect with redirect_pc=0x20 while the queue is full. Required: next cycle inst_valid=0, fill=0; the following cycle inst=1D24, inst_pc=0x20.
- redirect_pc=0xFE → inst_pc sequence FE, FF, 00, 01; imem_addr wraps to 00.
- en=0 with 2 queued entries and inst_ready=1 → two pops, then inst_valid=0, inst=0; imem_addr constant. en=1 → fetch resumes at the held address.
- Pull rst_n low between clock edges mid-stream → inst_valid, fill, inst, inst_pc go to 0 and imem_addr to RESET_PC before the next edge. After release, C005/00 is delivered first.
